serializer_word_feeder: RTL and testbench

Upstream companion of the mixed serializer: buffers parallel payload words from the core in a small FIFO and presents one word at a time on the serializer's parallel input. The serializer's ready pulse marks the capture of each word. The feeder inserts a sync word at a fixed period and an idle word when the FIFO runs dry. It runs on the serializer's slowest tree clock, so ready pulses are single-cycle in this domain.

---
 rtl/serializer_word_feeder.sv | 102 ++++++++++
 tb/tb_serializer_word_feeder.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serializer_word_feeder.sv
// Word feeder for the mixed serializer: FIFO-buffers core payload and presents one
// word per serializer ready pulse, inserting periodic sync words and idle on underrun.
module serializer_word_feeder #(
  parameter int unsigned      WIDTH       = 32,
  parameter int unsigned      DEPTH       = 8,
  parameter int unsigned      SYNC_PERIOD = 16,
  parameter logic [WIDTH-1:0] SYNC_WORD   = 32'hBC5A_5ABC,
  parameter logic [WIDTH-1:0] IDLE_WORD   = 32'h0000_0000
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic [WIDTH-1:0]         in_data_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  output logic [WIDTH-1:0]         ser_data_o,
  input  logic                     ser_ready_i,
  output logic [1:0]               kind_o,
  output logic [$clog2(DEPTH):0]   fill_o,
  output logic [15:0]              underrun_cnt_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned FW = AW + 1;
  localparam int unsigned SW = $clog2(SYNC_PERIOD);

  typedef enum logic [1:0] {
    KIND_DATA = 2'b00,
    KIND_IDLE = 2'b01,
    KIND_SYNC = 2'b10
  } kind_e;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [FW-1:0]    fill_q;
  logic [SW-1:0]    slot_q;
  logic [WIDTH-1:0] data_q;
  kind_e            kind_q;
  logic [15:0]      under_q;

  logic push, pop, sync_slot, fifo_empty;

  // Ready depends only on registered occupancy, so a pop never frees a slot
  // for a push in the same cycle.
  assign in_ready_o = (fill_q != FW'(DEPTH));
  assign fifo_empty = (fill_q == '0);
  assign sync_slot  = (slot_q == SW'(SYNC_PERIOD - 1));
  assign push       = in_valid_i & in_ready_o;
  assign pop        = ser_ready_i & ~sync_slot & ~fifo_empty;

  // NOTE: the payload array carries no reset; its contents are only ever read
  // behind the fill counter, and a reset branch would turn it into plain flops.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_q] <= in_data_i;
  end

  // NOTE: all state below updates with non-blocking assignments so every
  // decision in this block sees the pre-edge values (e.g. empty check before push).
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      slot_q   <= '0;
      data_q   <= SYNC_WORD;
      kind_q   <= KIND_SYNC;
      under_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);

      case ({push, pop})
        2'b10:   fill_q <= fill_q + FW'(1);
        2'b01:   fill_q <= fill_q - FW'(1);
        default: fill_q <= fill_q;
      endcase

      if (ser_ready_i) begin
        if (sync_slot) begin
          data_q <= SYNC_WORD;
          kind_q <= KIND_SYNC;
          slot_q <= '0;
        end else begin
          slot_q <= slot_q + SW'(1);
          if (!fifo_empty) begin
            data_q <= mem[rd_ptr_q];
            kind_q <= KIND_DATA;
          end else begin
            data_q <= IDLE_WORD;
            kind_q <= KIND_IDLE;
            if (under_q != 16'hFFFF) under_q <= under_q + 16'd1;
          end
        end
      end
    end
  end

  assign ser_data_o     = data_q;
  assign kind_o         = kind_q;
  assign fill_o         = fill_q;
  assign underrun_cnt_o = under_q;

endmodule

// File: tb/tb_serializer_word_feeder.sv
// Directed self-checking bench for serializer_word_feeder: reset, fill, sync
// framing, underrun and saturation, full-with-pop, and empty-push race.
module tb_serializer_word_feeder;

  localparam logic [31:0] SYNC_WORD = 32'hBC5A_5ABC;
  localparam logic [31:0] IDLE_WORD = 32'h0000_0000;

  logic        clk_i       = 1'b0;
  logic        reset_ni    = 1'b1;
  logic [31:0] in_data_i   = '0;
  logic        in_valid_i  = 1'b0;
  logic        in_ready_o;
  logic [31:0] ser_data_o;
  logic        ser_ready_i = 1'b0;
  logic [1:0]  kind_o;
  logic [3:0]  fill_o;
  logic [15:0] underrun_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  serializer_word_feeder #(
    .WIDTH(32), .DEPTH(8), .SYNC_PERIOD(16),
    .SYNC_WORD(SYNC_WORD), .IDLE_WORD(IDLE_WORD)
  ) dut (
    .clk_i          (clk_i),
    .reset_ni       (reset_ni),
    .in_data_i      (in_data_i),
    .in_valid_i     (in_valid_i),
    .in_ready_o     (in_ready_o),
    .ser_data_o     (ser_data_o),
    .ser_ready_i    (ser_ready_i),
    .kind_o         (kind_o),
    .fill_o         (fill_o),
    .underrun_cnt_o (underrun_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    reset_ni    = 1'b0;
    in_valid_i  = 1'b0;
    ser_ready_i = 1'b0;
    tick();
    reset_ni = 1'b1;
  endtask

  task automatic push_word(input logic [31:0] w);
    in_data_i  = w;
    in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
  endtask

  task automatic advance();
    ser_ready_i = 1'b1;
    tick();
    ser_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    #1 reset_ni = 1'b0;
    #1;
    n_checks++; if (ser_data_o !== SYNC_WORD) begin n_fail++; $display("FAIL rst0_data got=%h exp=%h", ser_data_o, SYNC_WORD); end
    n_checks++; if (kind_o !== 2'b10) begin n_fail++; $display("FAIL rst0_kind got=%b exp=10", kind_o); end
    n_checks++; if (fill_o !== 4'd0) begin n_fail++; $display("FAIL rst0_fill got=%0d exp=0", fill_o); end
    n_checks++; if (underrun_cnt_o !== 16'd0) begin n_fail++; $display("FAIL rst0_under got=%0d exp=0", underrun_cnt_o); end
    n_checks++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst0_ready got=%b exp=1", in_ready_o); end
    tick();
    reset_ni = 1'b1;

    for (int i = 0; i < 6; i++) push_word(32'hA000_0000 + i);
    advance();
    n_checks++; if (ser_data_o !== 32'hA000_0000 || kind_o !== 2'b00) begin n_fail++; $display("FAIL rst_pre_word got=%h/%b exp=a0000000/00", ser_data_o, kind_o); end
    n_checks++; if (fill_o !== 4'd5) begin n_fail++; $display("FAIL rst_pre_fill got=%0d exp=5", fill_o); end

    // Assert reset mid-cycle, well away from any clock edge.
    #3 reset_ni = 1'b0;
    #1;
    n_checks++; if (ser_data_o !== SYNC_WORD) begin n_fail++; $display("FAIL rst_mid_data got=%h exp=%h", ser_data_o, SYNC_WORD); end
    n_checks++; if (kind_o !== 2'b10) begin n_fail++; $display("FAIL rst_mid_kind got=%b exp=10", kind_o); end
    n_checks++; if (fill_o !== 4'd0) begin n_fail++; $display("FAIL rst_mid_fill got=%0d exp=0", fill_o); end
    n_checks++; if (underrun_cnt_o !== 16'd0) begin n_fail++; $display("FAIL rst_mid_under got=%0d exp=0", underrun_cnt_o); end
    n_checks++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready got=%b exp=1", in_ready_o); end
    tick();
    reset_ni = 1'b1;
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 8; i++) push_word(32'h1000_0000 + i);
    n_checks++; if (fill_o !== 4'd8) begin n_fail++; $display("FAIL fill_full got=%0d exp=8", fill_o); end
    n_checks++; if (in_ready_o !== 1'b0) begin n_fail++; $display("FAIL fill_ready got=%b exp=0", in_ready_o); end
    push_word(32'hDEAD_BEEF);
    n_checks++; if (fill_o !== 4'd8) begin n_fail++; $display("FAIL fill_ninth got=%0d exp=8", fill_o); end
    for (int i = 0; i < 8; i++) begin
      advance();
      n_checks++;
      if (ser_data_o !== 32'h1000_0000 + i || kind_o !== 2'b00) begin
        n_fail++; $display("FAIL fill_order[%0d] got=%h/%b exp=%h/00", i, ser_data_o, kind_o, 32'h1000_0000 + i);
      end
    end
    n_checks++; if (fill_o !== 4'd0) begin n_fail++; $display("FAIL fill_drained got=%0d exp=0", fill_o); end
    advance();
    n_checks++; if (ser_data_o !== IDLE_WORD || kind_o !== 2'b01) begin n_fail++; $display("FAIL fill_no_ninth got=%h/%b exp=%h/01", ser_data_o, kind_o, IDLE_WORD); end
  endtask

  task automatic test_sync_framing();
    int next_push;
    int next_pop;
    do_reset();
    for (int i = 0; i < 4; i++) push_word(32'h5000_0000 + i);
    next_push = 4;
    next_pop  = 0;
    for (int k = 1; k <= 32; k++) begin
      ser_ready_i = 1'b1;
      in_valid_i  = (next_push < 30);
      in_data_i   = 32'h5000_0000 + next_push;
      tick();
      if (in_valid_i) next_push++;
      if (k % 16 == 0) begin
        n_checks++;
        if (ser_data_o !== SYNC_WORD || kind_o !== 2'b10) begin
          n_fail++; $display("FAIL sync_slot[%0d] got=%h/%b exp=%h/10", k, ser_data_o, kind_o, SYNC_WORD);
        end
      end else begin
        n_checks++;
        if (ser_data_o !== 32'h5000_0000 + next_pop || kind_o !== 2'b00) begin
          n_fail++; $display("FAIL sync_data[%0d] got=%h/%b exp=%h/00", k, ser_data_o, kind_o, 32'h5000_0000 + next_pop);
        end
        next_pop++;
      end
    end
    ser_ready_i = 1'b0;
    in_valid_i  = 1'b0;
    n_checks++; if (fill_o !== 4'd0) begin n_fail++; $display("FAIL sync_final_fill got=%0d exp=0", fill_o); end
  endtask

  task automatic test_underrun();
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      advance();
      n_checks++;
      if (ser_data_o !== IDLE_WORD || kind_o !== 2'b01 || underrun_cnt_o !== 16'(i)) begin
        n_fail++; $display("FAIL underrun[%0d] got=%h/%b/%0d exp=%h/01/%0d", i, ser_data_o, kind_o, underrun_cnt_o, IDLE_WORD, i);
      end
    end
  endtask

  task automatic test_full_simultaneous();
    int  adv_n;
    int  next_push;
    int  next_pop;
    logic acc;
    do_reset();
    for (int i = 0; i < 8; i++) push_word(32'hF000_0000 + i);
    n_checks++; if (fill_o !== 4'd8 || in_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_pre got=%0d/%b exp=8/0", fill_o, in_ready_o); end

    in_valid_i  = 1'b1;
    in_data_i   = 32'hF000_0008;
    ser_ready_i = 1'b1;
    tick();
    ser_ready_i = 1'b0;
    n_checks++; if (ser_data_o !== 32'hF000_0000 || kind_o !== 2'b00) begin n_fail++; $display("FAIL full_pop got=%h/%b exp=f0000000/00", ser_data_o, kind_o); end
    n_checks++; if (fill_o !== 4'd7) begin n_fail++; $display("FAIL full_rejected got=%0d exp=7", fill_o); end
    n_checks++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL full_ready_after got=%b exp=1", in_ready_o); end
    tick();
    in_valid_i = 1'b0;
    n_checks++; if (fill_o !== 4'd8) begin n_fail++; $display("FAIL full_accept got=%0d exp=8", fill_o); end

    adv_n     = 1;
    next_push = 9;
    next_pop  = 1;
    for (int c = 0; c < 60 && next_pop < 20; c++) begin
      ser_ready_i = 1'b1;
      in_valid_i  = (next_push < 20);
      in_data_i   = 32'hF000_0000 + next_push;
      acc         = in_valid_i & in_ready_o;
      tick();
      if (acc) next_push++;
      adv_n++;
      if (adv_n % 16 == 0) begin
        n_checks++;
        if (ser_data_o !== SYNC_WORD || kind_o !== 2'b10) begin
          n_fail++; $display("FAIL wrap_sync[%0d] got=%h/%b exp=%h/10", adv_n, ser_data_o, kind_o, SYNC_WORD);
        end
      end else begin
        n_checks++;
        if (ser_data_o !== 32'hF000_0000 + next_pop || kind_o !== 2'b00) begin
          n_fail++; $display("FAIL wrap_order[%0d] got=%h/%b exp=%h/00", next_pop, ser_data_o, kind_o, 32'hF000_0000 + next_pop);
        end
        next_pop++;
      end
    end
    ser_ready_i = 1'b0;
    in_valid_i  = 1'b0;
    if (next_pop < 20) begin
      n_checks++; n_fail++;
      $display("FAIL wrap_timeout popped=%0d exp=20", next_pop);
    end
    n_checks++; if (fill_o !== 4'd0) begin n_fail++; $display("FAIL wrap_final_fill got=%0d exp=0", fill_o); end
  endtask

  task automatic test_empty_push_race();
    do_reset();
    in_data_i   = 32'hE000_0001;
    in_valid_i  = 1'b1;
    ser_ready_i = 1'b1;
    tick();
    in_valid_i  = 1'b0;
    ser_ready_i = 1'b0;
    n_checks++; if (ser_data_o !== IDLE_WORD || kind_o !== 2'b01) begin n_fail++; $display("FAIL race_idle got=%h/%b exp=%h/01", ser_data_o, kind_o, IDLE_WORD); end
    n_checks++; if (fill_o !== 4'd1) begin n_fail++; $display("FAIL race_fill got=%0d exp=1", fill_o); end
    advance();
    n_checks++; if (ser_data_o !== 32'hE000_0001 || kind_o !== 2'b00) begin n_fail++; $display("FAIL race_next got=%h/%b exp=e0000001/00", ser_data_o, kind_o); end
    n_checks++; if (fill_o !== 4'd0) begin n_fail++; $display("FAIL race_fill_after got=%0d exp=0", fill_o); end
  endtask

  task automatic test_saturation();
    int adv_n;
    int idles;
    int got;
    do_reset();
    adv_n = 0;
    idles = 0;
    ser_ready_i = 1'b1;
    while (idles < 65534) begin
      tick();
      adv_n++;
      if (adv_n % 16 != 0) idles++;
    end
    ser_ready_i = 1'b0;
    n_checks++; if (underrun_cnt_o !== 16'hFFFE) begin n_fail++; $display("FAIL sat_pre got=%h exp=fffe", underrun_cnt_o); end
    for (int round = 0; round < 2; round++) begin
      got = 0;
      while (got < 2 - round) begin
        advance();
        adv_n++;
        if (adv_n % 16 != 0) got++;
      end
      n_checks++;
      if (underrun_cnt_o !== 16'hFFFF || kind_o !== 2'b01) begin
        n_fail++; $display("FAIL sat_hold[%0d] got=%h/%b exp=ffff/01", round, underrun_cnt_o, kind_o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_sync_framing();
    test_underrun();
    test_full_simultaneous();
    test_empty_push_race();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
